// File: rtl/tracer_store_contour_ctrl_if.sv
// Contour store bus bundle: the 1-bit contour pixel stream (valid/ready/data)
// and the tracer buffer BRAM port (en/we/addr/dout/din).
//   master : the store controller (accepts pixels, drives the BRAM port)
//   slave  : the producer/BRAM side (drives pixels, returns read data)
interface tracer_store_contour_ctrl_if;
  logic        contour_valid;
  logic        contour_data;
  logic        contour_ready;
  logic        tracer_buf_en;
  logic [3:0]  tracer_buf_we;
  logic [31:0] tracer_buf_addr;
  logic [31:0] tracer_buf_dout;
  logic [31:0] tracer_buf_din;

  modport master (
    input  contour_valid,
    input  contour_data,
    output contour_ready,
    output tracer_buf_en,
    output tracer_buf_we,
    output tracer_buf_addr,
    output tracer_buf_dout,
    input  tracer_buf_din
  );

  modport slave (
    output contour_valid,
    output contour_data,
    input  contour_ready,
    input  tracer_buf_en,
    input  tracer_buf_we,
    input  tracer_buf_addr,
    input  tracer_buf_dout,
    output tracer_buf_din
  );
endinterface

// File: rtl/tracer_store_contour_ctrl.sv
// tracer_store_contour_ctrl: packs a serial stream of 1-bit contour pixels into the tracer
// buffer bit-plane layout by read-modify-write on 32-bit words. Pixel k goes to
//   word = BASE_WORD + PLANE_WORDS*block + (k mod PLANE_WORDS), bit = plane,
// with cnt_pixel running fastest, then plane, then block.
//
// Ports:
//   s_axi_aclk          clock
//   s_axi_areset        synchronous active-high reset
//   store_contour_start one-cycle pulse starting a frame (ignored while busy)
//   store_contour_busy  frame in progress
//   store_contour_done  one-cycle pulse after the last write
//   bus                 contour stream + BRAM port (tracer_store_contour_ctrl_if.master)
//
// Optional feature macro: TRACER_STORE_PLANE0_DIRECT_EN
//   When defined, plane-0 pixels skip the read and write {31'd0, bit} directly; later planes
//   restore the upper bits, so the final frame image is the same in both builds.
module tracer_store_contour_ctrl #(
  parameter int unsigned BASE_WORD   = 64,
  parameter int unsigned PLANE_WORDS = 625,
  parameter int unsigned PLANES      = 32,
  parameter int unsigned BLOCKS      = 2
) (
  input  logic s_axi_aclk,
  input  logic s_axi_areset,
  input  logic store_contour_start,
  output logic store_contour_busy,
  output logic store_contour_done,
  tracer_store_contour_ctrl_if.master bus
);

  localparam int unsigned CntW   = (PLANE_WORDS > 1) ? $clog2(PLANE_WORDS) : 1;
  localparam int unsigned PlaneW = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int unsigned BlkW   = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;

  localparam logic [CntW-1:0]   CntLast    = CntW'(PLANE_WORDS - 1);
  localparam logic [PlaneW-1:0] PlaneLast  = PlaneW'(PLANES - 1);
  localparam logic [BlkW-1:0]   BlkLast    = BlkW'(BLOCKS - 1);
  localparam logic [10:0]       BaseWord   = 11'(BASE_WORD);
  localparam logic [10:0]       PlaneWords = 11'(PLANE_WORDS);

  typedef enum logic [2:0] {StIdle, StAccept, StRd, StLat, StWr, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_pixel_q;
  logic [PlaneW-1:0] plane_q;
  logic [BlkW-1:0]   block_q;
  logic [10:0]       block_base_q;
  logic [10:0]       word_q;
  logic              bit_q;

  logic              ready_q;
  logic              en_q;
  logic [3:0]        we_q;
  logic [31:0]       dout_q;
  logic              busy_q;
  logic              done_q;

  logic [10:0]       word_sum;
  logic [31:0]       merged;
  logic              last_pixel;

  always_comb begin
    word_sum        = block_base_q + 11'(cnt_pixel_q);
    // Read data with only the selected plane bit replaced.
    merged          = bus.tracer_buf_din;
    merged[plane_q] = bit_q;
    last_pixel      = (cnt_pixel_q == CntLast) && (plane_q == PlaneLast) && (block_q == BlkLast);
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state_q      <= StIdle;
      cnt_pixel_q  <= '0;
      plane_q      <= '0;
      block_q      <= '0;
      block_base_q <= '0;
      word_q       <= '0;
      bit_q        <= 1'b0;
      ready_q      <= 1'b0;
      en_q         <= 1'b0;
      we_q         <= 4'h0;
      dout_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (store_contour_start) begin
            cnt_pixel_q  <= '0;
            plane_q      <= '0;
            block_q      <= '0;
            block_base_q <= BaseWord;
            state_q      <= StAccept;
            ready_q      <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        StAccept: begin
          if (bus.contour_valid) begin
            bit_q   <= bus.contour_data;
            word_q  <= word_sum;
            ready_q <= 1'b0;
            en_q    <= 1'b1;
`ifdef TRACER_STORE_PLANE0_DIRECT_EN
            if (plane_q == '0) begin
              // Plane 0 is written first, so the old word content is not needed.
              we_q    <= 4'hF;
              dout_q  <= {31'd0, bus.contour_data};
              state_q <= StWr;
            end else begin
`else
            begin
`endif
              we_q    <= 4'h0;
              state_q <= StRd;
            end
          end
        end
        StRd: begin
          en_q    <= 1'b0;
          state_q <= StLat;
        end
        StLat: begin
          // Read data is valid now; the merge is captured straight into the write register.
          en_q    <= 1'b1;
          we_q    <= 4'hF;
          dout_q  <= merged;
          state_q <= StWr;
        end
        StWr: begin
          en_q <= 1'b0;
          we_q <= 4'h0;
          if (cnt_pixel_q == CntLast) begin
            cnt_pixel_q <= '0;
            if (plane_q == PlaneLast) begin
              plane_q      <= '0;
              block_q      <= block_q + 1'b1;
              block_base_q <= block_base_q + PlaneWords;
            end else begin
              plane_q <= plane_q + 1'b1;
            end
          end else begin
            cnt_pixel_q <= cnt_pixel_q + 1'b1;
          end
          if (last_pixel) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            ready_q <= 1'b1;
            state_q <= StAccept;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.contour_ready   = ready_q;
  assign bus.tracer_buf_en   = en_q;
  assign bus.tracer_buf_we   = we_q;
  assign bus.tracer_buf_addr = {19'd0, word_q, 2'd0};
  assign bus.tracer_buf_dout = dout_q;
  assign store_contour_busy  = busy_q;
  assign store_contour_done  = done_q;

endmodule

// File: tb/tb_tracer_store_contour_ctrl.sv
// Scoreboard bench for tracer_store_contour_ctrl on a reduced geometry (25 words per plane,
// 32 planes, 2 blocks) so that several complete frames stay short. Expected writes are pushed
// when a pixel handshake occurs; a monitor pops and compares every observed BRAM write.
module tb_tracer_store_contour_ctrl;

  localparam int unsigned BASE  = 64;
  localparam int unsigned PW    = 25;
  localparam int unsigned PL    = 32;
  localparam int unsigned BL    = 2;
  localparam int unsigned FRAME = PW * PL;
  localparam int unsigned NPIX  = FRAME * BL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic done;

  tracer_store_contour_ctrl_if bus ();

  tracer_store_contour_ctrl #(
    .BASE_WORD   (BASE),
    .PLANE_WORDS (PW),
    .PLANES      (PL),
    .BLOCKS      (BL)
  ) dut (
    .s_axi_aclk          (clk),
    .s_axi_areset        (rst),
    .store_contour_start (start),
    .store_contour_busy  (busy),
    .store_contour_done  (done),
    .bus                 (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] v;
    v = (i * 32'h9E37_79B9) ^ 32'h5BD1_E995;
    if (i == int'(BASE)) v = 32'hA5A5_A5A5;
    return v;
  endfunction

  // BRAM model: one-cycle read latency.
  logic [31:0] mem [0:2047];
  logic        mem_init = 1'b1;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 2048; i++) mem[i] <= init_word(i);
    end else if (bus.tracer_buf_en) begin
      if (bus.tracer_buf_we == 4'hF) mem[bus.tracer_buf_addr[12:2]] <= bus.tracer_buf_dout;
      bus.tracer_buf_din <= mem[bus.tracer_buf_addr[12:2]];
    end
  end

  typedef struct packed {
    int          k;
    int unsigned word;
    logic [31:0] data;
    int unsigned h;
    int unsigned due;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ref_mem [0:2047];
  logic [31:0] img_a   [0:2047];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_done = 0;
  int unsigned last_wr = 0;
  int unsigned obs_word [0:NPIX-1];
  logic [31:0] obs_data [0:NPIX-1];
  int unsigned obs_lat  [0:NPIX-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic pat(input int k);
    logic [31:0] kk;
    kk = k;
    return kk[0] ^ kk[7];
  endfunction

  // Monitor: every write must match the oldest outstanding expectation.
  exp_t e;
  always @(negedge clk) begin
    if (bus.tracer_buf_en && bus.tracer_buf_we != 4'h0) begin
      check("we_full", {28'd0, bus.tracer_buf_we}, 32'hF);
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, expected no write",
                 bus.tracer_buf_addr, bus.tracer_buf_dout);
      end else begin
        e = q.pop_front();
        check($sformatf("addr_px%0d", e.k), bus.tracer_buf_addr, e.word * 4);
        check($sformatf("data_px%0d", e.k), bus.tracer_buf_dout, e.data);
        check($sformatf("latency_px%0d", e.k), cyc, e.due);
        obs_word[e.k] = bus.tracer_buf_addr[12:2];
        obs_data[e.k] = bus.tracer_buf_dout;
        obs_lat[e.k]  = cyc - e.h;
      end
      last_wr = cyc;
    end
    if (done) begin
      n_done++;
      check("done_after_last_write", cyc, last_wr + 1);
      check("done_queue_empty", q.size(), 0);
    end
  end

  // Reference model: pixel k -> (word, bit), computed from the layout rules directly.
  task automatic push_pixel(input int k, input logic d, input int unsigned h,
                            output int unsigned word, output logic [31:0] old);
    int          blk;
    int          b;
    int unsigned lat;
    logic [31:0] nw;
    blk  = k / FRAME;
    b    = (k % FRAME) / PW;
    word = BASE + PW * blk + (k % PW);
    old  = ref_mem[word];
    nw   = old;
    nw[b] = d;
    lat  = 3;
`ifdef TRACER_STORE_PLANE0_DIRECT_EN
    if (b == 0) begin
      nw  = {31'd0, d};
      lat = 1;
    end
`endif
    ref_mem[word] = nw;
    q.push_back('{k: k, word: word, data: nw, h: h, due: h + lat});
  endtask

  task automatic run_frame(input int duty, input bit rnd, input int start_at, input int reset_at);
    int          k;
    int          stall;
    int          done0;
    bit          pulsed;
    logic        d;
    int unsigned w;
    logic [31:0] old;
    k      = 0;
    stall  = 0;
    pulsed = 0;
    done0  = n_done;
    @(posedge clk); #1;
    start = 1'b1;
    bus.contour_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("start_ready", {31'd0, bus.contour_ready}, 32'd1);
    check("start_busy", {31'd0, busy}, 32'd1);
    while (k < int'(NPIX)) begin
      @(posedge clk); #1;
      bus.contour_valid = (duty >= 100) ? 1'b1 : ($urandom_range(99) < duty);
      d = rnd ? 1'($urandom) : pat(k);
      bus.contour_data = d;
      start = (k == start_at) && !pulsed;
      if (start) pulsed = 1;
      @(negedge clk);
      if (bus.contour_ready) check("accept_bus_idle", {31'd0, bus.tracer_buf_en}, 32'd0);
      if (bus.contour_valid && bus.contour_ready) begin
        push_pixel(k, d, cyc, w, old);
        stall = 0;
        if (k == reset_at) begin
          // Reset in the RD cycle: this pixel's write must never appear.
          @(posedge clk); #1;
          rst = 1'b1;
          bus.contour_valid = 1'b0;
          start = 1'b0;
          @(posedge clk); #1;
          rst = 1'b0;
          @(negedge clk);
          check("reset_en", {31'd0, bus.tracer_buf_en}, 32'd0);
          check("reset_ready", {31'd0, bus.contour_ready}, 32'd0);
          check("reset_busy", {31'd0, busy}, 32'd0);
          void'(q.pop_back());
          ref_mem[w] = old;
          repeat (4) @(negedge clk);
          return;
        end
        k++;
      end else begin
        stall++;
        if (stall > 64) begin
          n_cmp++;
          n_err++;
          $display("FAIL handshake_timeout: pixel %0d, expected ready within 64 cycles", k);
          break;
        end
      end
    end
    @(posedge clk); #1;
    bus.contour_valid = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 16 && n_done == done0; i++) @(negedge clk);
    // Hold valid: no pixel beyond the frame may be accepted.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      bus.contour_valid = 1'b1;
      @(negedge clk);
      check("no_extra_pixel_ready", {31'd0, bus.contour_ready}, 32'd0);
    end
    @(posedge clk); #1;
    bus.contour_valid = 1'b0;
    @(negedge clk);
    check("done_pulse_count", n_done - done0, 1);
    check("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_region(input string name, input bit vs_img_a);
    for (int i = int'(BASE); i < int'(BASE + PW * BL); i++)
      check($sformatf("%s_w%0d", name, i), mem[i], vs_img_a ? img_a[i] : ref_mem[i]);
  endtask

  initial begin
    int unsigned tk [5];
    int unsigned tw [5];
    int          tb [5];
    logic [31:0] mw;
    tk = '{0, PW - 1, PW, FRAME, NPIX - 1};
    tw = '{BASE, BASE + PW - 1, BASE, BASE + PW, BASE + 2 * PW - 1};
    tb = '{0, 0, 1, 0, PL - 1};
    for (int i = 0; i < 2048; i++) ref_mem[i] = init_word(i);
    bus.contour_valid = 1'b0;
    bus.contour_data  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, bus.contour_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_en", {31'd0, bus.tracer_buf_en}, 32'd0);
    check("rst_we", {28'd0, bus.tracer_buf_we}, 32'd0);
    check("rst_addr", bus.tracer_buf_addr, 32'd0);
    check("rst_dout", bus.tracer_buf_dout, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_init = 1'b0;

    // Continuous frame with a stray start pulse mid-frame.
    run_frame(100, 1'b0, 500, -1);
`ifdef TRACER_STORE_PLANE0_DIRECT_EN
    check("rmw_first_data", obs_data[0], 32'h0000_0000);
    check("rmw_first_lat", obs_lat[0], 1);
`else
    check("rmw_first_data", obs_data[0], 32'hA5A5_A5A4);
    check("rmw_first_lat", obs_lat[0], 3);
`endif
    for (int i = 0; i < 5; i++) begin
      check($sformatf("map_word_px%0d", tk[i]), obs_word[tk[i]], tw[i]);
      mw = mem[tw[i]];
      check($sformatf("map_bit_px%0d", tk[i]), {31'd0, mw[tb[i]]}, {31'd0, pat(int'(tk[i]))});
    end
    check_region("frame_a", 1'b0);
    for (int i = 0; i < 2048; i++) img_a[i] = mem[i];

    // Same pixels with ~30% valid duty: identical image.
    run_frame(30, 1'b0, -1, -1);
    check_region("gaps_vs_a", 1'b1);

    // Reset mid-frame, then a full random frame from the top.
    run_frame(100, 1'b1, -1, 1000);
    run_frame(100, 1'b1, -1, -1);
    check("restart_first_word", obs_word[0], BASE);
    check_region("frame_d", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
